// File: rtl/panda_pc.sv
// panda_pc: fetch-stage program counter with jump/branch redirect.
// Optional stall input enabled by defining PANDA_PC_STALL_EN.
module panda_pc #(
    parameter int unsigned     Width    = 32,
    parameter logic [Width-1:0] BootAddr = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef PANDA_PC_STALL_EN
    input  logic             stall_i,
`endif
    input  logic             branch_i,
    input  logic             jump_i,
    input  logic [Width-1:0] branch_target_i,
    input  logic [Width-1:0] jump_target_i,
    output logic [Width-1:0] pc_o,
    output logic [Width-1:0] pc_inc_o
);

    localparam logic [Width-1:0] Step = Width'(4);

    logic [Width-1:0] pc_q;
    logic [Width-1:0] pc_next;
    logic             hold;

`ifdef PANDA_PC_STALL_EN
    assign hold = stall_i;
`else
    assign hold = 1'b0;
`endif

    // Sequential address wraps modulo 2^Width; carry-out is dropped.
    assign pc_inc_o = pc_q + Step;
    assign pc_o     = pc_q;

    // Next-PC select: jump beats branch, both beat stall and increment.
    always_comb begin
        pc_next = pc_inc_o;
        if (jump_i) begin
            pc_next = jump_target_i;
        end else if (branch_i) begin
            pc_next = branch_target_i;
        end else if (hold) begin
            pc_next = pc_q;
        end
    end

    // PC register; reset loads the boot address without waiting for a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= BootAddr;
        end else begin
            pc_q <= pc_next;
        end
    end

endmodule

// File: tb/tb_panda_pc.sv
// tb_panda_pc: directed and random checks of panda_pc
// against an arithmetic reference of the next-PC rules.
module tb_panda_pc;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic        jump;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] pc_inc;

    logic [31:0] exp_pc;
    int          passed = 0;
    int          total  = 0;

    localparam logic [31:0] Boot = 32'h0000_0000;

    panda_pc #(
        .Width    (32),
        .BootAddr (Boot)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
`ifdef PANDA_PC_STALL_EN
        .stall_i         (stall),
`endif
        .branch_i        (branch),
        .jump_i          (jump),
        .branch_target_i (branch_target),
        .jump_target_i   (jump_target),
        .pc_o            (pc),
        .pc_inc_o        (pc_inc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference next-PC computed from the architectural rules.
    function automatic logic [31:0] ref_next(input logic [31:0] cur);
        if (rst) return Boot;
        if (jump) return jump_target;
        if (branch) return branch_target;
`ifdef PANDA_PC_STALL_EN
        if (stall) return cur;
`endif
        return cur + 32'd4;
    endfunction

    task automatic step(input string tag);
        exp_pc = ref_next(exp_pc);
        @(posedge clk);
        #1;
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_inc"}, pc_inc, exp_pc + 32'd4);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        branch = 1'b0;
        jump = 1'b0;
        branch_target = '0;
        jump_target = '0;
        exp_pc = Boot;
        #1;
        check("reset_pc", pc, Boot);
        check("reset_inc", pc_inc, Boot + 32'd4);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("run");

        branch_target = 32'd24;
        branch = 1'b1;
        step("branch");
        branch = 1'b0;
        for (int i = 0; i < 3; i++) step("post_branch");

        jump_target = 32'd56;
        jump = 1'b1;
        step("jump");
        jump = 1'b0;
        for (int i = 0; i < 2; i++) step("post_jump");

        branch = 1'b1;
        jump = 1'b1;
        step("priority");
        step("held_redirect");
        branch = 1'b0;
        jump = 1'b0;

`ifdef PANDA_PC_STALL_EN
        stall = 1'b1;
        step("stall1");
        step("stall2");
        branch = 1'b1;
        step("stall_branch");
        branch = 1'b0;
        stall = 1'b0;
        step("unstall");
`endif

        jump_target = 32'hFFFF_FFFC;
        jump = 1'b1;
        step("to_top");
        jump = 1'b0;
        step("wrap");
        step("after_wrap");

        branch_target = 32'd100;
        branch = 1'b1;
        #2;
        rst = 1'b1;
        exp_pc = Boot;
        #1;
        check("async_rst_pc", pc, Boot);
        check("async_rst_inc", pc_inc, Boot + 32'd4);
        step("rst_edge");
        @(negedge clk);
        rst = 1'b0;
        branch = 1'b0;
        step("rst_release");

        for (int i = 0; i < 200; i++) begin
            jump = ($urandom_range(0, 7) == 0);
            branch = ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 3) == 0);
            jump_target = {$urandom, 2'b00} >> 0;
            jump_target[1:0] = 2'b00;
            branch_target = $urandom;
            branch_target[1:0] = 2'b00;
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
